fpadd_norm_round: RTL and testbench

Normalize-and-round back end of the single-precision floating-point adder. It consumes the raw 28-bit significand sum and carry-out produced by the Kogge-Stone adder's sum layer, together with the sign and biased exponent of the larger operand. It normalizes (1-bit right shift on carry-out, or leading-zero left shift after cancellation) and rounds to nearest-even. It packs an IEEE-754 binary32 result through a 3-stage valid/ready pipeline.

---
 rtl/fpadd_norm_round.sv | 159 +++++++++++++++
 tb/tb_fpadd_norm_round.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_norm_round.sv
// fpadd_norm_round: normalize-and-round back end of the binary32 adder.
// It takes the raw 28-bit significand sum and carry-out from the adder and
// produces a packed binary32 result with OVF/UNF/INEXACT flags. It is built
// as a 3-stage valid/ready pipeline in which all stages advance together.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   IN_VALID / IN_READY   input handshake
//   SUM[27:0]             hidden bit [27], fraction [26:4], G [3], R [2], sticky [1:0]
//   COUT                  carry-out of the significand add (sum >= 2.0)
//   SIGN_IN, EXP_IN[7:0]  sign and biased exponent of the larger operand
//   OUT_VALID / OUT_READY output handshake
//   RESULT[31:0]          {sign, exp[7:0], frac[22:0]}
//   OVF, UNF, INEXACT     overflow-to-inf, flush-to-zero, inexact
module fpadd_norm_round (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [27:0] SUM,
  input  logic        COUT,
  input  logic        SIGN_IN,
  input  logic [7:0]  EXP_IN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] RESULT,
  output logic        OVF,
  output logic        UNF,
  output logic        INEXACT
);

  // One shared advance enable: a stalled output freezes the whole pipe.
  logic en;
  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;

  // Stage 1: carry-out right shift or leading-zero count.
  logic [4:0] lzc;
  always_comb begin
    lzc = '0;
    // Ascending scan: the highest set bit writes last and wins.
    for (int i = 0; i < 28; i++) begin
      if (SUM[i]) lzc = 5'(27 - i);
    end
  end

  logic        v1, sign1, zero1, sticky1;
  logic [27:0] sig1;
  logic [4:0]  lzc1;
  logic [9:0]  e1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1      <= 1'b0;
      sign1   <= 1'b0;
      zero1   <= 1'b0;
      sticky1 <= 1'b0;
      sig1    <= '0;
      lzc1    <= '0;
      e1      <= '0;
    end else if (en) begin
      v1    <= IN_VALID;
      sign1 <= SIGN_IN;
      zero1 <= !COUT && (SUM == 28'd0);
      if (COUT) begin
        sig1    <= {1'b1, SUM[27:1]};
        sticky1 <= SUM[0];
        lzc1    <= '0;
        e1      <= {2'b00, EXP_IN} + 10'd1;
      end else begin
        sig1    <= SUM;
        sticky1 <= 1'b0;
        lzc1    <= lzc;
        e1      <= {2'b00, EXP_IN} - {5'b00000, lzc};
      end
    end
  end

  // Stage 2: normalizing left shift and G/R/S extraction.
  logic [27:0] shl;
  assign shl = sig1 << lzc1;

  logic        v2, sign2, zero2, g2, r2, s2;
  logic [23:0] m2;
  logic [9:0]  e2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      zero2 <= 1'b0;
      g2    <= 1'b0;
      r2    <= 1'b0;
      s2    <= 1'b0;
      m2    <= '0;
      e2    <= '0;
    end else if (en) begin
      v2    <= v1;
      sign2 <= sign1;
      zero2 <= zero1;
      m2    <= shl[27:4];
      g2    <= shl[3];
      r2    <= shl[2];
      s2    <= (|shl[1:0]) | sticky1;
      e2    <= e1;
    end
  end

  // Stage 3: round to nearest-even, renormalize on rounding carry, pack.
  logic        round_up;
  logic [24:0] mr;
  logic [22:0] frac;
  logic [9:0]  e3;

  always_comb begin
    round_up = g2 & (r2 | s2 | m2[0]);
    mr       = {1'b0, m2} + {24'd0, round_up};
    // A carry into bit 24 leaves the significand at exactly 2.0, so the
    // shifted-out bit is always zero and needs no second rounding.
    frac     = mr[24] ? mr[23:1] : mr[22:0];
    e3       = e2 + {9'd0, mr[24]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      RESULT    <= '0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
      INEXACT   <= 1'b0;
    end else if (en) begin
      OUT_VALID <= v2;
      if (v2) begin
        if (zero2) begin
          RESULT  <= 32'h0000_0000;
          OVF     <= 1'b0;
          UNF     <= 1'b0;
          INEXACT <= 1'b0;
        end else if ($signed(e3) <= 10'sd0) begin
          RESULT  <= {sign2, 31'd0};
          OVF     <= 1'b0;
          UNF     <= 1'b1;
          INEXACT <= 1'b1;
        end else if ($signed(e3) >= 10'sd255) begin
          RESULT  <= {sign2, 8'hFF, 23'd0};
          OVF     <= 1'b1;
          UNF     <= 1'b0;
          INEXACT <= 1'b1;
        end else begin
          RESULT  <= {sign2, e3[7:0], frac};
          OVF     <= 1'b0;
          UNF     <= 1'b0;
          INEXACT <= g2 | r2 | s2;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpadd_norm_round.sv
// Directed testbench for fpadd_norm_round. Inputs are driven 1 ns after a
// rising edge, and outputs are sampled at that same point.
module tb_fpadd_norm_round;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [27:0] SUM;
  logic        COUT;
  logic        SIGN_IN;
  logic [7:0]  EXP_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RESULT;
  logic        OVF;
  logic        UNF;
  logic        INEXACT;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fpadd_norm_round dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SUM(SUM), .COUT(COUT), .SIGN_IN(SIGN_IN), .EXP_IN(EXP_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .OVF(OVF), .UNF(UNF), .INEXACT(INEXACT)
  );

  // Directed vectors: cout, sum, exp, sign -> result, {ovf,unf,inexact}
  localparam int NV = 11;
  logic        v_cout [NV];
  logic [27:0] v_sum  [NV];
  logic [7:0]  v_exp  [NV];
  logic        v_sign [NV];
  logic [31:0] v_res  [NV];
  logic [2:0]  v_flg  [NV];

  initial begin
    v_cout[0]=0; v_sum[0]=28'h0000010; v_exp[0]=8'd130; v_sign[0]=0; v_res[0]=32'h35800000; v_flg[0]=3'b000;
    v_cout[1]=0; v_sum[1]=28'h0000010; v_exp[1]=8'd10;  v_sign[1]=0; v_res[1]=32'h00000000; v_flg[1]=3'b011;
    v_cout[2]=0; v_sum[2]=28'h8000008; v_exp[2]=8'd127; v_sign[2]=0; v_res[2]=32'h3F800000; v_flg[2]=3'b001;
    v_cout[3]=0; v_sum[3]=28'h8000018; v_exp[3]=8'd127; v_sign[3]=0; v_res[3]=32'h3F800002; v_flg[3]=3'b001;
    v_cout[4]=0; v_sum[4]=28'hFFFFFF8; v_exp[4]=8'd127; v_sign[4]=0; v_res[4]=32'h40000000; v_flg[4]=3'b001;
    v_cout[5]=1; v_sum[5]=28'h0000000; v_exp[5]=8'd254; v_sign[5]=1; v_res[5]=32'hFF800000; v_flg[5]=3'b101;
    v_cout[6]=0; v_sum[6]=28'h0000000; v_exp[6]=8'd100; v_sign[6]=1; v_res[6]=32'h00000000; v_flg[6]=3'b000;
    v_cout[7]=1; v_sum[7]=28'h0000001; v_exp[7]=8'd127; v_sign[7]=0; v_res[7]=32'h40000000; v_flg[7]=3'b001;
    v_cout[8]=0; v_sum[8]=28'h8000000; v_exp[8]=8'd127; v_sign[8]=1; v_res[8]=32'hBF800000; v_flg[8]=3'b000;
    v_cout[9]=0; v_sum[9]=28'h8000009; v_exp[9]=8'd127; v_sign[9]=0; v_res[9]=32'h3F800001; v_flg[9]=3'b001;
    v_cout[10]=0; v_sum[10]=28'h4000000; v_exp[10]=8'd1; v_sign[10]=1; v_res[10]=32'h80000000; v_flg[10]=3'b011;
  end

  task automatic drive(input logic c, input logic [27:0] s, input logic [7:0] e, input logic sg);
    COUT = c; SUM = s; EXP_IN = e; SIGN_IN = sg; IN_VALID = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    COUT = 1'b0; SUM = '0; EXP_IN = '0; SIGN_IN = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    n_vec++;
    if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    n_vec++;
    if (RESULT !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 00000000", RESULT); end
    n_vec++;
    if ({OVF, UNF, INEXACT} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {OVF, UNF, INEXACT}); end
    n_vec++;
    if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    RST = 1'b0;
    @(posedge CLK); #1;
    n_vec++;
    if (RESULT !== 32'h0 || OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL idle_hold got valid=%b result=%h want 0/00000000", OUT_VALID, RESULT);
    end
  endtask

  task automatic test_latency;
    OUT_READY = 1'b1;
    drive(1'b1, 28'h0, 8'd127, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      if (c < 3) begin
        n_vec++;
        if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL latency_early edge %0d got valid=%b want 0", c, OUT_VALID); end
      end
    end
    n_vec++;
    if (OUT_VALID !== 1'b1 || RESULT !== 32'h40000000 || {OVF, UNF, INEXACT} !== 3'b000) begin
      n_bad++;
      $display("FAIL one_plus_one got valid=%b result=%h flags=%b want 1/40000000/000",
               OUT_VALID, RESULT, {OVF, UNF, INEXACT});
    end
    @(posedge CLK); #1;
    n_vec++;
    if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL bubble_after got valid=%b want 0", OUT_VALID); end
  endtask

  task automatic test_vectors;
    OUT_READY = 1'b1;
    for (int k = 0; k < NV; k++) begin
      drive(v_cout[k], v_sum[k], v_exp[k], v_sign[k]);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      n_vec++;
      if (OUT_VALID !== 1'b1 || RESULT !== v_res[k] || {OVF, UNF, INEXACT} !== v_flg[k]) begin
        n_bad++;
        $display("FAIL vector_%0d got valid=%b result=%h flags=%b want 1/%h/%b",
                 k, OUT_VALID, RESULT, {OVF, UNF, INEXACT}, v_res[k], v_flg[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    OUT_READY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(v_cout[c], v_sum[c], v_exp[c], v_sign[c]);
      else IN_VALID = 1'b0;
      @(posedge CLK); #1;
      if (c >= 2) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || RESULT !== v_res[c-2] || {OVF, UNF, INEXACT} !== v_flg[c-2]) begin
          n_bad++;
          $display("FAIL b2b_%0d got valid=%b result=%h flags=%b want 1/%h/%b",
                   c - 2, OUT_VALID, RESULT, {OVF, UNF, INEXACT}, v_res[c-2], v_flg[c-2]);
        end
      end
    end
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure;
    int          sent = 0;
    int          got = 0;
    bit          acc_in, stall_prev, saw_stall;
    logic [31:0] held_res;
    logic [2:0]  held_flg;
    logic [31:0] want;
    stall_prev = 1'b0; saw_stall = 1'b0;
    held_res = '0; held_flg = '0;
    for (int cyc = 0; cyc < 60 && !(sent == 5 && got == 5); cyc++) begin
      OUT_READY = (cyc < 2 || cyc >= 12);
      if (sent < 5) drive(1'b0, 28'h8000000 | (28'(sent) << 4), 8'(127 + sent), 1'b0);
      else IN_VALID = 1'b0;
      #1;
      if (stall_prev) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || RESULT !== held_res || {OVF, UNF, INEXACT} !== held_flg) begin
          n_bad++;
          $display("FAIL stall_hold cyc %0d got valid=%b result=%h want 1/%h", cyc, OUT_VALID, RESULT, held_res);
        end
      end
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b0) begin
        saw_stall = 1'b1;
        n_vec++;
        if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, IN_READY); end
      end
      acc_in = IN_VALID && IN_READY;
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        want = {1'b0, 8'(127 + got), 23'(got)};
        n_vec++;
        if (RESULT !== want || {OVF, UNF, INEXACT} !== 3'b000) begin
          n_bad++;
          $display("FAIL bp_order beat %0d got %h flags=%b want %h/000", got, RESULT, {OVF, UNF, INEXACT}, want);
        end
        got++;
      end
      stall_prev = OUT_VALID && !OUT_READY;
      held_res = RESULT;
      held_flg = {OVF, UNF, INEXACT};
      @(posedge CLK); #1;
      if (acc_in) sent++;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    n_vec++;
    if (got != 5 || sent != 5) begin n_bad++; $display("FAIL bp_count got sent=%0d recv=%0d want 5/5", sent, got); end
    n_vec++;
    if (!saw_stall) begin n_bad++; $display("FAIL bp_stall_seen got 0 want 1"); end
    @(posedge CLK); #1;
    n_vec++;
    if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup got valid=%b want 0", OUT_VALID); end
  endtask

  task automatic test_reset_midstream;
    bit leaked = 1'b0;
    OUT_READY = 1'b1;
    drive(1'b0, 28'h8000000, 8'd127, 1'b0);
    @(posedge CLK); #1;
    drive(1'b0, 28'h8000010, 8'd127, 1'b0);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    n_vec++;
    if (OUT_VALID !== 1'b1 || RESULT !== 32'h3F800000) begin
      n_bad++; $display("FAIL pre_reset_beat got valid=%b result=%h want 1/3F800000", OUT_VALID, RESULT);
    end
    #2 RST = 1'b1;
    #1;
    n_vec++;
    if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid got %b want 0", OUT_VALID); end
    n_vec++;
    if (RESULT !== 32'h0) begin n_bad++; $display("FAIL async_reset_result got %h want 00000000", RESULT); end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      if (OUT_VALID !== 1'b0) leaked = 1'b1;
    end
    n_vec++;
    if (leaked) begin n_bad++; $display("FAIL post_reset_leak got 1 want 0"); end
    drive(1'b0, 28'h8000000, 8'd128, 1'b1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    n_vec++;
    if (OUT_VALID !== 1'b1 || RESULT !== 32'hC0000000) begin
      n_bad++; $display("FAIL post_reset_beat got valid=%b result=%h want 1/C0000000", OUT_VALID, RESULT);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_vectors;
    test_back_to_back;
    test_backpressure;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
